// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter in front of one mode-0 SPI master; each grant runs one full-duplex frame.
// Grant and response pulses are registered; responses have no backpressure.
module spi_master_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_LENGTH = 8,
  parameter int CLK_DIV     = 4,
  parameter int SS_GAP      = 2,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  output logic [DATA_LENGTH-1:0]         rsp_data,
  output logic [ID_W-1:0]                rsp_id,
  output logic                           busy,
  output logic                           SCLK,
  output logic                           MOSI,
  input  logic                           MISO,
  output logic                           SS
);

  localparam int GAP_CYC = SS_GAP * CLK_DIV;
  localparam int DIV_MAX = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int BIT_W   = $clog2(DATA_LENGTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    HOLD,
    GAP
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [DIV_W-1:0]       div_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_LENGTH-1:0] tx_sh;
  logic [DATA_LENGTH-1:0] rx_sh;
  logic [ID_W-1:0]        id;
  logic [ID_W-1:0]        last_grant;

  logic                   grant_found;
  logic [ID_W-1:0]        grant_idx;
  logic [NUM_REQ-1:0]     grant_oh;
  logic [DATA_LENGTH-1:0] grant_data;
  int                     cand;

  logic phase_end;
  logic gap_end;
  logic last_bit;

  assign phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign gap_end   = (div_cnt == DIV_W'(GAP_CYC - 1));
  assign last_bit  = (bit_cnt == BIT_W'(DATA_LENGTH));
  assign busy      = (state != IDLE);

  // Scan starts one past the previous winner, so a steady set of requesters rotates.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    grant_data  = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grant_found && (j == cand) && req_valid[j]) begin
          grant_found = 1'b1;
          grant_idx   = ID_W'(j);
          grant_oh[j] = 1'b1;
          grant_data  = req_data[j*DATA_LENGTH +: DATA_LENGTH];
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant_found) state_nxt = LEAD;
      LEAD: if (phase_end) state_nxt = HIGH;
      HIGH: if (phase_end) state_nxt = last_bit ? HOLD : LEAD;
      HOLD: if (phase_end) state_nxt = GAP;
      GAP:  if (gap_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      id         <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      req_ready  <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      SCLK       <= 1'b0;
      MOSI       <= 1'b0;
      SS         <= 1'b1;
    end else begin
      state     <= state_nxt;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      // The divider restarts on every state change and is parked in IDLE.
      if ((state == IDLE) || (state_nxt != state)) div_cnt <= '0;
      else                                         div_cnt <= div_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (grant_found) begin
            req_ready  <= grant_oh;
            tx_sh      <= grant_data;
            id         <= grant_idx;
            last_grant <= grant_idx;
            SS         <= 1'b0;
            MOSI       <= grant_data[DATA_LENGTH-1];
            bit_cnt    <= '0;
          end
        end
        LEAD: begin
          if (phase_end) begin
            SCLK    <= 1'b1;
            rx_sh   <= {rx_sh[DATA_LENGTH-2:0], MISO};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            SCLK <= 1'b0;
            if (!last_bit) begin
              tx_sh <= tx_sh << 1;
              MOSI  <= tx_sh[DATA_LENGTH-2];
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            SS        <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= rx_sh;
            rsp_id    <= id;
          end
        end
        default: ;
      endcase
    end
  end

  a_idle_lines : assert property (@(posedge clk) disable iff (rst) SS |-> (!SCLK && !MOSI));
  a_one_grant  : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_ss     : assert property (@(posedge clk) disable iff (rst) rsp_valid |-> SS);

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a mode-0 slave model and link monitors.
module tb_spi_master_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [0:0]  rsp_id;
  logic        busy;
  logic        SCLK;
  logic        MOSI;
  logic        MISO = 1'b0;
  logic        SS;

  always #5 clk = ~clk;

  spi_master_arbiter #(
    .NUM_REQ(2), .DATA_LENGTH(8), .CLK_DIV(4), .SS_GAP(2)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS(SS)
  );

  int n_cmp = 0;
  int n_err = 0;

  int         rise_total = 0;
  logic [7:0] mosi_sh = 8'h00;
  logic [1:0] grant_q[$];
  logic [8:0] rsp_q[$];
  int cur_low = 0, last_low = 0, cur_high = 0, last_high = 0;
  int ones = 0, zeros = 0, idle_viol = 0, mosi_viol = 0;
  logic ss_prev = 1'b1, sclk_prev = 1'b0, mosi_prev = 1'b0;
  logic [7:0] slave_tx = 8'h00, slave_sh = 8'h00;

  always @(posedge SCLK) begin
    rise_total++;
    mosi_sh = {mosi_sh[6:0], MOSI};
  end

  // Link monitor plus slave: loads on SS fall, shifts on SCLK fall.
  always @(posedge clk) begin
    #1;
    if (req_ready != 2'b00) grant_q.push_back(req_ready);
    if (rsp_valid === 1'b1) rsp_q.push_back({rsp_id, rsp_data});
    if (SS === 1'b0) begin
      cur_low++;
      if (cur_high > 0) begin last_high = cur_high; cur_high = 0; end
      if (MOSI === 1'b1) ones++; else zeros++;
      if (ss_prev === 1'b1) begin
        slave_sh = slave_tx;
        MISO = slave_sh[7];
      end else if (sclk_prev === 1'b1 && SCLK === 1'b0) begin
        slave_sh = slave_sh << 1;
        MISO = slave_sh[7];
      end
    end else if (SS === 1'b1) begin
      cur_high++;
      if (cur_low > 0) begin last_low = cur_low; cur_low = 0; end
      if (SCLK !== 1'b0 || MOSI !== 1'b0) idle_viol++;
    end
    if (SCLK === 1'b1 && sclk_prev === 1'b1 && MOSI !== mosi_prev) mosi_viol++;
    ss_prev = SS;
    sclk_prev = SCLK;
    mosi_prev = MOSI;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grants(input int target, input string tag);
    for (int i = 0; i < 3000 && grant_q.size() < target; i++) @(negedge clk);
    chk(tag, grant_q.size(), target);
  endtask

  task automatic wait_rsps(input int target, input string tag);
    for (int i = 0; i < 3000 && rsp_q.size() < target; i++) @(negedge clk);
    chk(tag, rsp_q.size(), target);
  endtask

  initial begin
    int gb, rb, r0, o0, z0;
    logic [8:0] e;

    // Reset state and a single 0xA5 / 0x3C frame.
    do_reset();
    chk("rst_ss", SS, 1);
    chk("rst_sclk", SCLK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    gb = grant_q.size(); rb = rsp_q.size(); r0 = rise_total;
    slave_tx = 8'h3C; req_data = 16'h00A5; req_valid = 2'b01;
    wait_grants(gb + 1, "t1_grant");
    req_valid = 2'b00;
    chk("t1_grant_vec", grant_q[gb], 2'b01);
    wait_rsps(rb + 1, "t1_rsp");
    e = rsp_q[rb];
    chk("t1_rsp_data", e[7:0], 8'h3C);
    chk("t1_rsp_id", e[8], 0);
    chk("t1_mosi_bits", mosi_sh, 8'hA5);
    chk("t1_rises", rise_total - r0, 8);
    chk("t1_ss_low", last_low, 68);
    repeat (7) @(negedge clk);
    chk("t1_busy_gap", busy, 1);
    repeat (2) @(negedge clk);
    chk("t1_busy_idle", busy, 0);
    chk("t1_rsp_count", rsp_q.size() - rb, 1);

    // Both requesters held from reset alternate strictly.
    do_reset();
    gb = grant_q.size(); rb = rsp_q.size();
    slave_tx = 8'h96; req_data = 16'h5AC3; req_valid = 2'b11;
    wait_grants(gb + 4, "t2_grants");
    req_valid = 2'b00;
    wait_rsps(rb + 4, "t2_rsps");
    for (int k = 0; k < 4; k++) begin
      e = rsp_q[rb + k];
      chk($sformatf("t2_grant%0d", k), grant_q[gb + k], (k % 2 == 1) ? 2'b10 : 2'b01);
      chk($sformatf("t2_id%0d", k), e[8], k % 2);
    end
    chk("t2_data", e[7:0], 8'h96);
    chk("t2_mosi_last", mosi_sh, 8'h5A);
    chk("t2_ss_gap", last_high, 9);

    // Requester 1 alone first, then both: pointer hands the next turn to 0.
    do_reset();
    gb = grant_q.size(); rb = rsp_q.size();
    req_valid = 2'b10;
    wait_grants(gb + 1, "t3_g1");
    req_valid = 2'b11;
    wait_grants(gb + 3, "t3_g3");
    req_valid = 2'b00;
    wait_rsps(rb + 3, "t3_rsps");
    chk("t3_grant0", grant_q[gb], 2'b10);
    chk("t3_grant1", grant_q[gb + 1], 2'b01);
    chk("t3_grant2", grant_q[gb + 2], 2'b10);

    // Reset one cycle after the 4th SCLK rise aborts the frame.
    do_reset();
    chk("t4_rst_rsp_data", rsp_data, 0);
    chk("t4_rst_rsp_id", rsp_id, 0);
    gb = grant_q.size(); rb = rsp_q.size(); r0 = rise_total;
    req_valid = 2'b01;
    wait_grants(gb + 1, "t4_grant");
    req_valid = 2'b00;
    for (int i = 0; i < 500 && (rise_total - r0) < 4; i++) @(negedge clk);
    chk("t4_rises", rise_total - r0, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_ss", SS, 1);
    chk("t4_sclk", SCLK, 0);
    chk("t4_mosi", MOSI, 0);
    chk("t4_busy", busy, 0);
    repeat (80) @(negedge clk);
    chk("t4_no_rsp", rsp_q.size() - rb, 0);
    chk("t4_no_grant", grant_q.size() - gb, 1);
    req_valid = 2'b11;
    wait_grants(gb + 2, "t4_regrant");
    req_valid = 2'b00;
    chk("t4_grant_after_rst", grant_q[gb + 1], 2'b01);
    wait_rsps(rb + 1, "t4_rsp");

    // All-ones out with MISO low, then all-zeros out with MISO high.
    gb = grant_q.size(); rb = rsp_q.size(); o0 = ones; z0 = zeros;
    slave_tx = 8'h00; req_data = 16'h00FF; req_valid = 2'b01;
    wait_grants(gb + 1, "t5a_grant");
    req_valid = 2'b00;
    wait_rsps(rb + 1, "t5a_rsp");
    e = rsp_q[rb];
    chk("t5a_data", e[7:0], 8'h00);
    chk("t5a_mosi_ones", ones - o0, 68);
    chk("t5a_mosi_zeros", zeros - z0, 0);
    o0 = ones; z0 = zeros;
    slave_tx = 8'hFF; req_data = 16'h0000; req_valid = 2'b10;
    wait_grants(gb + 2, "t5b_grant");
    req_valid = 2'b00;
    wait_rsps(rb + 2, "t5b_rsp");
    e = rsp_q[rb + 1];
    chk("t5b_data", e[7:0], 8'hFF);
    chk("t5b_id", e[8], 1);
    chk("t5b_mosi_zeros", zeros - z0, 68);
    chk("t5b_mosi_ones", ones - o0, 0);

    // A request raised and dropped inside a frame is never seen.
    gb = grant_q.size(); rb = rsp_q.size();
    slave_tx = 8'h81; req_data = 16'h0033; req_valid = 2'b01;
    wait_grants(gb + 1, "t6_grant");
    req_valid = 2'b00;
    repeat (20) @(negedge clk);
    req_valid = 2'b10;
    repeat (10) @(negedge clk);
    req_valid = 2'b00;
    wait_rsps(rb + 1, "t6_rsp");
    repeat (30) @(negedge clk);
    chk("t6_grants", grant_q.size() - gb, 1);
    chk("t6_rsps", rsp_q.size() - rb, 1);
    e = rsp_q[rb];
    chk("t6_data", e[7:0], 8'h81);

    chk("idle_lines_low", idle_viol, 0);
    chk("mosi_stable_high", mosi_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
